instr_encoder_loader: RTL and testbench

//  Counterpart of the CPU opcode decoder: packs decoded instruction fields (op, rs, rt, rd, funct, imm)

---
 rtl/instr_encoder_loader_pkg.sv | 36 +++
 rtl/instr_encoder_loader_if.sv | 32 +++
 rtl/instr_encoder_loader_pack.sv | 26 ++
 rtl/instr_encoder_loader.sv | 107 ++++++++++
 tb/tb_instr_encoder_loader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared ISA definitions: opcodes, field positions and the decoded-field bundle.
// The CPU control unit decodes against these same constants.
package instr_encoder_loader_pkg;

  localparam int INSTR_W = 24;

  localparam logic [3:0] OP_RTYPE = 4'b0110;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LS    = 4'b0010;
  localparam logic [3:0] OP_SS    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;

  localparam int OP_LSB    = 20;
  localparam int RS_LSB    = 16;
  localparam int RT_LSB    = 12;
  localparam int RD_LSB    = 8;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} loadState_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  rd;
    logic [7:0]  funct;
    logic [11:0] imm;
  } instrFields_t;

  function automatic logic isLegalOp(input logic [3:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LS) ||
           (op == OP_SS) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-beat input, instruction-memory write port and session status of the loader.
interface instr_encoder_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [3:0]        in_rs;
  logic [3:0]        in_rt;
  logic [3:0]        in_rd;
  logic [7:0]        in_funct;
  logic [11:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err_illegal;
  logic              err_full;
  logic [ADDR_W:0]   count;

  modport master (
    output start, base_addr, in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_illegal, err_full, count
  );

  modport slave (
    input  start, base_addr, in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err_illegal, err_full, count
  );
endinterface

// File: rtl/instr_encoder_loader_pack.sv
// Combinational packer: decoded fields -> 24-bit instruction word plus legal-opcode flag.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  instrFields_t       fields,
  output logic [INSTR_W-1:0] word,
  output logic               legal
);

  always_comb begin
    word = '0;
    word[OP_LSB +: 4] = fields.op;
    word[RS_LSB +: 4] = fields.rs;
    word[RT_LSB +: 4] = fields.rt;
    // Only R-format carries rd/funct; every other legal format carries the immediate there.
    if (fields.op == OP_RTYPE) begin
      word[RD_LSB +: 4]    = fields.rd;
      word[FUNCT_LSB +: 8] = fields.funct;
    end else begin
      word[IMM_LSB +: 12] = fields.imm;
    end
  end

  assign legal = isLegalOp(fields.op);

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams packed instruction words into instruction memory at consecutive addresses.
// One word per cycle; write appears one cycle after the accepting handshake.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_encoder_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loadState_t         state, nextState;
  logic               inReady;
  logic               accept;
  logic               doWrite;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W:0]    cnt;
  logic               errIllegal, errFull;
  logic               memWe;
  logic [ADDR_W-1:0]  memAddr;
  logic [INSTR_W-1:0] memWdata;
  logic [INSTR_W-1:0] word;
  logic               legal;
  instrFields_t       fields;

  assign fields = '{op: bus.in_op, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                    funct: bus.in_funct, imm: bus.in_imm};

  instr_pack uPack (
    .fields (fields),
    .word   (word),
    .legal  (legal)
  );

  assign accept  = inReady && bus.in_valid;
  assign doWrite = accept && (state == LOAD) && legal;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    inReady   = 1'b0;
    case (state)
      IDLE: if (bus.start) nextState = LOAD;
      LOAD: begin
        inReady = 1'b1;
        if (accept) begin
          if (bus.in_last)                        nextState = DONE;
          else if (doWrite && addr == LAST_ADDR) nextState = FULL;
        end
      end
      FULL: begin
        inReady = 1'b1;
        if (accept && bus.in_last) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      cnt        <= '0;
      errIllegal <= 1'b0;
      errFull    <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
    end else begin
      memWe <= doWrite;
      if (state == IDLE && bus.start) begin
        addr       <= bus.base_addr;
        cnt        <= '0;
        errIllegal <= 1'b0;
        errFull    <= 1'b0;
      end
      if (doWrite) begin
        memAddr  <= addr;
        memWdata <= word;
        addr     <= addr + 1'b1;
        cnt      <= cnt + 1'b1;
      end
      if (accept && state == LOAD && !legal) errIllegal <= 1'b1;
      // Anything accepted once the top word is written is an overflow attempt.
      if (accept && state == FULL) errFull <= 1'b1;
    end
  end

  assign bus.in_ready    = inReady;
  assign bus.mem_we      = memWe;
  assign bus.mem_addr    = memAddr;
  assign bus.mem_wdata   = memWdata;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.err_illegal = errIllegal;
  assign bus.err_full    = errFull;
  assign bus.count       = cnt;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: drives on negedge, samples on negedge.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   doneCnt = 0;
  logic randGaps = 1'b0;

  typedef struct {
    logic [7:0]  addr;
    logic [23:0] data;
  } wr_t;
  wr_t wq[$];

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(8)) bus ();

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wq.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
    if (bus.done === 1'b1) doneCnt++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic startSession(input logic [7:0] base);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic sendBeat(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                          input logic [3:0] rd, input logic [7:0] funct, input logic [11:0] imm,
                          input logic last);
    bit ok = 0;
    if (randGaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_funct = funct; bus.in_imm = imm; bus.in_last = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    if (!ok) checkVal("beat_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    @(negedge clk);
    if (!ok) checkVal("idle_timeout", 0, 1);
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [7:0] a, input logic [23:0] d);
    if (idx < wq.size()) begin
      checkVal({tag, "_addr"}, 32'(wq[idx].addr), 32'(a));
      checkVal({tag, "_data"}, 32'(wq[idx].data), 32'(d));
    end else begin
      checkVal({tag, "_missing"}, 32'(wq.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int d0;
    bus.start = 0; bus.base_addr = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_rs = 0;
    bus.in_rt = 0; bus.in_rd = 0; bus.in_funct = 0; bus.in_imm = 0; bus.in_last = 0;

    // 1: reset state and single ADDI
    repeat (3) @(negedge clk);
    checkVal("rst_in_ready", 32'(bus.in_ready), 0);
    checkVal("rst_mem_we", 32'(bus.mem_we), 0);
    checkVal("rst_busy_done", {bus.busy, bus.done}, 0);
    checkVal("rst_errs", {bus.err_illegal, bus.err_full}, 0);
    checkVal("rst_addr_data", {bus.mem_addr, bus.mem_wdata}, 0);
    checkVal("rst_count", 32'(bus.count), 0);
    reset = 1'b0;
    @(negedge clk);
    d0 = doneCnt;
    startSession(8'h10);
    checkVal("t1_busy", 32'(bus.busy), 1);
    sendBeat(4'h1, 4'h1, 4'h2, 4'h0, 8'h00, 12'h005, 1'b1);
    checkVal("t1_we", 32'(bus.mem_we), 1);
    checkVal("t1_addr", 32'(bus.mem_addr), 32'h10);
    checkVal("t1_data", 32'(bus.mem_wdata), 32'h112005);
    checkVal("t1_done", 32'(bus.done), 1);
    checkVal("t1_ready_low", 32'(bus.in_ready), 0);
    @(negedge clk);
    checkVal("t1_done_once", 32'(bus.done), 0);
    checkVal("t1_idle", 32'(bus.busy), 0);
    checkVal("t1_count", 32'(bus.count), 1);
    checkVal("t1_done_cnt", 32'(doneCnt - d0), 1);

    // 2: R-type then BEQ with negative offset
    wq.delete();
    startSession(8'h20);
    sendBeat(4'h6, 4'h1, 4'h2, 4'h3, 8'h20, 12'h000, 1'b0);
    sendBeat(4'h4, 4'h3, 4'h3, 4'h0, 8'h00, 12'hFFE, 1'b1);
    waitIdle();
    checkVal("t2_nwr", 32'(wq.size()), 2);
    checkWrite("t2_w0", 0, 8'h20, 24'h612320);
    checkWrite("t2_w1", 1, 8'h21, 24'h433FFE);
    checkVal("t2_count", 32'(bus.count), 2);
    checkVal("t2_err_illegal", 32'(bus.err_illegal), 0);

    // 3: illegal opcode mid-stream, then illegal opcode as last beat
    wq.delete();
    startSession(8'h30);
    sendBeat(4'h1, 4'h1, 4'h2, 4'h0, 8'h00, 12'h001, 1'b0);
    sendBeat(4'hF, 4'h5, 4'h5, 4'h5, 8'h55, 12'h555, 1'b0);
    sendBeat(4'h1, 4'h3, 4'h4, 4'h0, 8'h00, 12'h002, 1'b1);
    waitIdle();
    checkVal("t3_nwr", 32'(wq.size()), 2);
    checkWrite("t3_w0", 0, 8'h30, 24'h112001);
    checkWrite("t3_w1", 1, 8'h31, 24'h134002);
    checkVal("t3_err_illegal", 32'(bus.err_illegal), 1);
    checkVal("t3_count", 32'(bus.count), 2);
    wq.delete();
    d0 = doneCnt;
    startSession(8'h40);
    checkVal("t3b_err_cleared", 32'(bus.err_illegal), 0);
    sendBeat(4'h3, 4'h2, 4'h7, 4'h0, 8'h00, 12'h010, 1'b0);
    sendBeat(4'h9, 4'h0, 4'h0, 4'h0, 8'h00, 12'h000, 1'b1);
    waitIdle();
    checkVal("t3b_nwr", 32'(wq.size()), 1);
    checkWrite("t3b_w0", 0, 8'h40, 24'h327010);
    checkVal("t3b_err_illegal", 32'(bus.err_illegal), 1);
    checkVal("t3b_done", 32'(doneCnt - d0), 1);

    // 4: overflow at top of memory
    wq.delete();
    d0 = doneCnt;
    startSession(8'd254);
    sendBeat(4'h1, 4'h1, 4'h1, 4'h0, 8'h00, 12'h00A, 1'b0);
    sendBeat(4'h1, 4'h1, 4'h1, 4'h0, 8'h00, 12'h00B, 1'b0);
    sendBeat(4'h1, 4'h1, 4'h1, 4'h0, 8'h00, 12'h00C, 1'b1);
    waitIdle();
    checkVal("t4_nwr", 32'(wq.size()), 2);
    checkWrite("t4_w0", 0, 8'd254, 24'h11100A);
    checkWrite("t4_w1", 1, 8'd255, 24'h11100B);
    checkVal("t4_err_full", 32'(bus.err_full), 1);
    checkVal("t4_count", 32'(bus.count), 2);
    checkVal("t4_done", 32'(doneCnt - d0), 1);

    // 5: random valid gaps over 8 beats
    wq.delete();
    randGaps = 1'b1;
    startSession(8'h50);
    for (int i = 0; i < 8; i++)
      sendBeat(4'h1, 4'(i), 4'(i + 1), 4'h0, 8'h00, 12'(12'h100 + i), 1'(i == 7));
    randGaps = 1'b0;
    waitIdle();
    checkVal("t5_nwr", 32'(wq.size()), 8);
    for (int i = 0; i < 8; i++)
      checkWrite($sformatf("t5_w%0d", i), i, 8'(8'h50 + i),
                 {4'h1, 4'(i), 4'(i + 1), 12'(12'h100 + i)});
    checkVal("t5_count", 32'(bus.count), 8);

    // 6: reset mid-session, start while busy, valid in IDLE
    startSession(8'h60);
    sendBeat(4'h1, 4'h2, 4'h2, 4'h0, 8'h00, 12'h0AA, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkVal("t6_rst_we", 32'(bus.mem_we), 0);
    checkVal("t6_rst_busy", 32'(bus.busy), 0);
    checkVal("t6_rst_count", 32'(bus.count), 0);
    reset = 1'b0;
    wq.delete();
    startSession(8'h70);
    sendBeat(4'h2, 4'h1, 4'h3, 4'h0, 8'h00, 12'h004, 1'b0);
    bus.start = 1'b1;
    bus.base_addr = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    sendBeat(4'h2, 4'h1, 4'h3, 4'h0, 8'h00, 12'h008, 1'b1);
    waitIdle();
    checkVal("t6_nwr", 32'(wq.size()), 2);
    checkWrite("t6_w0", 0, 8'h70, 24'h213004);
    checkWrite("t6_w1", 1, 8'h71, 24'h213008);
    checkVal("t6_count", 32'(bus.count), 2);
    bus.in_valid = 1'b1;
    bus.in_op = 4'h1;
    repeat (3) @(negedge clk);
    checkVal("t6_idle_ready", 32'(bus.in_ready), 0);
    checkVal("t6_idle_nwr", 32'(wq.size()), 2);
    bus.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
